// File: rtl/bcd_time_editor.sv
// MM:SS time-set editor: synchronised push buttons edit a packed-BCD value
// under a one-hot cursor; a one-cycle finish pulse marks the end of an edit.
module bcd_time_editor #(
  parameter int MIN_TENS_MAX = 5,
  parameter int SEC_TENS_MAX = 5,
  parameter int UNITS_MAX    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] load_value,
  input  logic        push_u,
  input  logic        push_d,
  input  logic        push_l,
  input  logic        push_r,
  output logic [15:0] num,
  output logic [3:0]  sel,
  output logic        editing,
  output logic        finish
);

  typedef enum logic [1:0] {IDLE = 2'd0, EDIT = 2'd1, COMMIT = 2'd2} state_t;

  state_t      state, state_next;
  logic [3:0]  sync_p0, sync_p1, hist_p2;
  logic [3:0]  press;
  logic [15:0] num_next;
  logic [3:0]  sel_next;
  logic        editing_next, finish_next;

  function automatic logic [3:0] digit_max(input int idx);
    case (idx)
      3:       return 4'(MIN_TENS_MAX);
      1:       return 4'(SEC_TENS_MAX);
      default: return 4'(UNITS_MAX);
    endcase
  endfunction

  function automatic logic [15:0] sanitise(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++)
      if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = 4'd0;
    return r;
  endfunction

  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] mx);
    return (d >= mx) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] mx);
    return (d == 4'd0 || d > mx) ? mx : d - 4'd1;
  endfunction

  // Button stage: two sync flops then a history flop; bit order {u,d,l,r}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 4'b0000;
      sync_p1 <= 4'b0000;
      hist_p2 <= 4'b0000;
    end else begin
      sync_p0 <= {push_u, push_d, push_l, push_r};
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign press = sync_p1 & ~hist_p2;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      num     <= 16'h0000;
      sel     <= 4'b0000;
      editing <= 1'b0;
      finish  <= 1'b0;
    end else begin
      state   <= state_next;
      num     <= num_next;
      sel     <= sel_next;
      editing <= editing_next;
      finish  <= finish_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = EDIT;
      EDIT:    if (!enable) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output values for the next cycle; u > d > l > r, lower events dropped
  always_comb begin
    num_next     = num;
    sel_next     = 4'b0000;
    editing_next = (state_next == EDIT);
    finish_next  = (state_next == COMMIT);
    case (state)
      IDLE: begin
        if (enable) begin
          num_next = sanitise(load_value);
          sel_next = 4'b1000;
        end
      end
      EDIT: begin
        if (enable) begin
          sel_next = sel;
          if (press[3]) begin
            for (int i = 0; i < 4; i++)
              if (sel[i]) num_next[4*i +: 4] = digit_inc(num[4*i +: 4], digit_max(i));
          end else if (press[2]) begin
            for (int i = 0; i < 4; i++)
              if (sel[i]) num_next[4*i +: 4] = digit_dec(num[4*i +: 4], digit_max(i));
          end else if (press[1]) begin
            sel_next = {sel[2:0], sel[3]};
          end else if (press[0]) begin
            sel_next = {sel[0], sel[3:1]};
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_time_editor.sv
// Bench for bcd_time_editor: scripted scenarios with literal expectations,
// then randomized traffic compared every cycle against a digit-level model.
module tb_bcd_time_editor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic        push_u = 1'b0, push_d = 1'b0, push_l = 1'b0, push_r = 1'b0;
  logic [15:0] num;
  logic [3:0]  sel;
  logic        editing, finish;

  int errors = 0;
  int checks = 0;

  bcd_time_editor dut (
    .clk(clk), .reset(reset), .enable(enable), .load_value(load_value),
    .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
    .num(num), .sel(sel), .editing(editing), .finish(finish)
  );

  always #5 clk = ~clk;

  // Model: digits[0] is leftmost, cur is cursor position from the left,
  // mode 0=idle 1=edit 2=commit, hq holds button levels of the last 3 edges.
  int       lim[4] = '{5, 9, 5, 9};
  int       md[4] = '{0, 0, 0, 0};
  int       cur = 0;
  int       mode = 0;
  bit [3:0] hq[$] = '{4'h0, 4'h0, 4'h0};
  bit [3:0] m_ev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) md[i] = 0;
      cur = 0;
      mode = 0;
      hq = '{4'h0, 4'h0, 4'h0};
    end else begin
      m_ev = hq[1] & ~hq[0];
      hq.push_back({push_u, push_d, push_l, push_r});
      void'(hq.pop_front());
      case (mode)
        0: if (enable) begin
          for (int i = 0; i < 4; i++) begin
            md[i] = int'((load_value >> (12 - 4*i)) & 16'hF);
            if (md[i] > lim[i]) md[i] = 0;
          end
          cur = 0;
          mode = 1;
        end
        1: begin
          if (!enable) mode = 2;
          else if (m_ev[3]) md[cur] = (md[cur] + 1) % (lim[cur] + 1);
          else if (m_ev[2]) md[cur] = (md[cur] + lim[cur]) % (lim[cur] + 1);
          else if (m_ev[1]) cur = (cur + 3) % 4;
          else if (m_ev[0]) cur = (cur + 1) % 4;
        end
        default: mode = 0;
      endcase
    end
  end

  function automatic logic [15:0] m_num();
    return {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
  endfunction

  function automatic logic [15:0] m_sel();
    return (mode == 1) ? (16'h0008 >> cur) : 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_num", num, m_num());
    chk("model_sel", {12'h0, sel}, m_sel());
    chk("model_editing", {15'h0, editing}, (mode == 1) ? 16'h1 : 16'h0);
    chk("model_finish", {15'h0, finish}, (mode == 2) ? 16'h1 : 16'h0);
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input logic [3:0] m);
    {push_u, push_d, push_l, push_r} = m;
  endtask

  task automatic press(input logic [3:0] m);
    drive(m);
    tick();
    drive(4'b0000);
    tick();
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_num", num, 16'h0000);
    chk("rst_sel", {12'h0, sel}, 16'h0000);
    chk("rst_editing", {15'h0, editing}, 16'h0);
    chk("rst_finish", {15'h0, finish}, 16'h0);
    reset = 1'b0;

    load_value = 16'h1234; enable = 1'b1; tick();
    chk("t1_num", num, 16'h1234);
    chk("t1_sel", {12'h0, sel}, 16'h0008);
    chk("t1_editing", {15'h0, editing}, 16'h1);
    enable = 1'b0; tick();
    chk("t1_finish", {15'h0, finish}, 16'h1);
    chk("t1_sel_commit", {12'h0, sel}, 16'h0000);
    chk("t1_num_commit", num, 16'h1234);
    tick();
    chk("t1_finish_drop", {15'h0, finish}, 16'h0);

    load_value = 16'h5000; enable = 1'b1; tick();
    press(4'b1000);
    chk("t2_up_wrap", num, 16'h0000);
    press(4'b0100);
    chk("t2_down_wrap", num, 16'h5000);
    enable = 1'b0; tick(); tick();
    load_value = 16'h0009; enable = 1'b1; tick();
    press(4'b0010);
    chk("t3_left_wrap", {12'h0, sel}, 16'h0001);
    press(4'b1000);
    chk("t2_units_wrap", num, 16'h0000);

    drive(4'b0001); tick(); tick();
    chk("t3_r_before", {12'h0, sel}, 16'h0001);
    tick();
    chk("t3_r_third_edge", {12'h0, sel}, 16'h0008);
    repeat (17) tick();
    chk("t3_r_held", {12'h0, sel}, 16'h0008);
    drive(4'b0000); repeat (4) tick();
    chk("t3_r_release", {12'h0, sel}, 16'h0008);

    press(4'b1010);
    chk("t4_num", num, 16'h1000);
    chk("t4_sel", {12'h0, sel}, 16'h0008);

    enable = 1'b0; tick(); tick();
    load_value = 16'hF6A9; enable = 1'b1; tick();
    chk("t5_sanitise", num, 16'h0609);
    enable = 1'b0; tick(); tick();
    press(4'b1000);
    press(4'b0001);
    chk("t5_idle_num", num, 16'h0609);
    chk("t5_idle_finish", {15'h0, finish}, 16'h0);

    load_value = 16'h1345; enable = 1'b1; tick();
    press(4'b1000);
    chk("t6_edit", num, 16'h2345);
    reset = 1'b1; #1;
    chk("t6_rst_num", num, 16'h0000);
    chk("t6_rst_sel", {12'h0, sel}, 16'h0000);
    chk("t6_rst_editing", {15'h0, editing}, 16'h0);
    chk("t6_rst_finish", {15'h0, finish}, 16'h0);
    tick();
    load_value = 16'h0123; reset = 1'b0; tick();
    chk("t6_reentry_num", num, 16'h0123);
    chk("t6_reentry_editing", {15'h0, editing}, 16'h1);

    repeat (3000) begin
      tick();
      drive({$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
      if ($urandom_range(0, 11) == 0) enable = ~enable;
      load_value = 16'($urandom);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_time_editor.md
Name: bcd_time_editor

Overview:
- Upstream edit stage for the MM:SS clock. Operators use it to set the clock time with the up/down/left/right push buttons while the time-set switch is on.
- Produces a 4-digit packed-BCD value, a one-hot cursor for the blinking digit, and a one-cycle finish pulse. The top level loads the time counter from the value on that pulse.
- Contains its own button synchronisers and rising-edge detectors. One press gives exactly one action.

Parameters:
- MIN_TENS_MAX, 5, upper limit of minutes-tens digit num[15:12]
- SEC_TENS_MAX, 5, upper limit of seconds-tens digit num[7:4]
- UNITS_MAX, 9, upper limit of units digits num[11:8] and num[3:0]

Ports:
- clk  input  1  system tick clock; all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  time-set mode switch (SPDT1), level-sensitive
- load_value  input  16  packed BCD time, captured on entry to edit
- push_u  input  1  raw button: increment selected digit
- push_d  input  1  raw button: decrement selected digit
- push_l  input  1  raw button: move cursor left
- push_r  input  1  raw button: move cursor right
- num  output  16  packed BCD being edited; [15:12] = leftmost digit
- sel  output  4  one-hot cursor; bit3 = leftmost digit (num[15:12]); 0 when not editing
- editing  output  1  high while in EDIT state
- finish  output  1  one-cycle pulse on leaving edit mode

Behaviour:
- Reset values (async, while reset=1):
  - num=16'h0000, sel=4'b0000, editing=0, finish=0
  - state=IDLE; all synchroniser and edge flops = 0
- Button path, per button:
  - 2-flop synchroniser s1→s2, then history flop s3; press event = s2 & ~s3.
  - The synchronisers run in every state.
  - A push going high before clock edge k sets the event during the cycle after edge k+1; its action takes effect at edge k+2.
  - A held button yields one event only; release produces no event.
- Priority when several events occur in one cycle: u > d > l > r. Only the highest is acted on; the others are discarded.
- FSM has 3 states:
  - IDLE:
    - sel=0, editing=0; num holds its last value; press events are ignored.
    - When enable=1: num <= sanitised load_value, sel <= 4'b1000, go to EDIT.
    - Any press event in the entry cycle is ignored.
  - EDIT:
    - editing=1.
    - If enable=0: go to COMMIT. Any press event in that cycle is ignored.
    - Otherwise apply the highest-priority event:
      - up: selected digit +1; wraps from its max to 0 (5→0 for tens digits, 9→0 for units)
      - down: selected digit −1; wraps from 0 to its max
      - left: sel rotates left; 4'b1000 → 4'b0001
      - right: sel rotates right; 4'b0001 → 4'b1000
    - Only the selected digit changes. The other 12 bits of num are unchanged.
  - COMMIT:
    - finish=1 for exactly this cycle; sel=0; num stable and equal to the final edited value.
    - Next state is always IDLE, even if enable is already high again. Re-entry therefore happens no sooner than 2 cycles after COMMIT.
- Sanitising on load: any digit above its limit becomes 0; all other digits pass unchanged. Example: 16'h7A59 loads as 16'h0059.
- Digit arithmetic is 4-bit BCD only. num never holds a digit above its limit, in any state.
- All outputs are registered. No combinational path from any push or enable input to any output.
- Reset asserted mid-edit aborts the edit: finish does not pulse, num returns to 0.
- Deasserting reset while enable=1 enters EDIT on the first clock edge after release, loading load_value.
- finish never pulses without a preceding EDIT state.

Test Plan:
1. Entry/exit: reset, then load_value=16'h1234, enable=1 → next edge num=16'h1234, sel=4'b1000, editing=1. Then enable=0 → finish high exactly 1 cycle, sel=0, num=16'h1234.
2. Digit wrap: in EDIT with sel=4'b1000 and num=16'h5000, one press of push_u → num=16'h0000. Then one press of push_d → 16'h5000. Move cursor to sel=4'b0001 with num=16'h0009, press push_u → 16'h0000.
3. Cursor wrap and single-action: press push_l at sel=4'b1000 → sel=4'b0001. Hold push_r for 20 cycles → sel advances exactly one position, to 4'b1000. The update lands on the third edge after the press.
4. Simultaneous events: push_u and push_l rise on the same cycle, num=16'h0000, sel=4'b1000 → num=16'h1000, sel unchanged.
5. Sanitise and ignore: load_value=16'hF6A9 → num=16'h0609. Presses while enable=0 leave num unchanged and finish stays 0.
6. Reset mid-edit: edit num to 16'h2345, assert reset asynchronously between edges → num=0, sel=0, editing=0 immediately, and no finish pulse.
